// File: rtl/fifo_stream_reader.sv
// Drains an upstream synchronous FIFO (1-cycle read latency) into a valid/ready
// stream through a 3-entry skid buffer, so FIFO pops never depend on m_ready.
module fifo_stream_reader #(
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fifo_empty,
  input  logic [D_WIDTH-1:0] fifo_dout,
  output logic               fifo_rd_en,
  input  logic               flush,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [D_WIDTH-1:0] m_data,
  output logic [1:0]         occupancy
);

  localparam logic [1:0] LAST_SLOT = 2'd2;
  localparam logic [2:0] DEPTH     = 3'd3;

  logic [D_WIDTH-1:0] buffer_reg [3];
  logic [1:0]         head_reg;
  logic [1:0]         head_next;
  logic [1:0]         tail_reg;
  logic [1:0]         tail_next;
  logic [1:0]         count_reg;
  logic [1:0]         count_next;
  logic               inflight_reg;
  logic [2:0]         level;
  logic               capture;
  logic               pop;

  function automatic logic [1:0] wrap_inc(input logic [1:0] ptr);
    return (ptr == LAST_SLOT) ? 2'd0 : ptr + 2'd1;
  endfunction

  // Reserve a slot for the word still in flight so a capture can never overflow.
  always_comb begin
    level      = {1'b0, count_reg} + {2'b00, inflight_reg};
    fifo_rd_en = !rst && !flush && !fifo_empty && (level < DEPTH);
  end

  assign m_valid   = (count_reg != 2'd0);
  assign occupancy = count_reg;

  always_comb begin
    m_data = buffer_reg[0];
    case (head_reg)
      2'd1:    m_data = buffer_reg[1];
      2'd2:    m_data = buffer_reg[2];
      default: m_data = buffer_reg[0];
    endcase
  end

  assign capture = inflight_reg && !flush;
  assign pop     = m_valid && m_ready && !flush;

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (flush) begin
      head_next  = 2'd0;
      tail_next  = 2'd0;
      count_next = 2'd0;
    end else begin
      if (capture) tail_next = wrap_inc(tail_reg);
      if (pop)     head_next = wrap_inc(head_reg);
      case ({capture, pop})
        2'b10:   count_next = count_reg + 2'd1;
        2'b01:   count_next = count_reg - 2'd1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg     <= 2'd0;
      tail_reg     <= 2'd0;
      count_reg    <= 2'd0;
      inflight_reg <= 1'b0;
    end else begin
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      count_reg    <= count_next;
      inflight_reg <= fifo_rd_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) buffer_reg[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < 3; i++) begin
        if (tail_reg == i[1:0]) buffer_reg[i] <= fifo_dout;
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural upstream FIFO plus an in-order
// scoreboard; scenario tasks add cycle-exact checks.
module tb_fifo_stream_reader;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         fifo_empty;
  logic [W-1:0] fifo_dout;
  logic         fifo_rd_en;
  logic         flush;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic [1:0]   occupancy;

  logic [W-1:0] mem [16384];
  int unsigned  wr_ptr;
  int unsigned  rd_ptr;
  logic [W-1:0] exp_q [$];
  int           checks = 0;
  int           errors = 0;
  int           delivered = 0;
  logic         stall_prev;
  logic [W-1:0] stall_data;

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  fifo_stream_reader #(.D_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .occupancy  (occupancy)
  );

  task automatic push_word(input logic [W-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  function automatic bit idle();
    return fifo_empty && (exp_q.size() == 0) && (occupancy == 2'd0) && !m_valid;
  endfunction

  // One clock: upstream FIFO model, scoreboard push on pop, compare on handshake.
  task automatic tick();
    logic [W-1:0] e;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== stall_data) begin
          errors++;
          $display("FAIL hold: valid=%b data=%h, required valid=1 data=%h", m_valid, m_data, stall_data);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        delivered++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_word: got %h, required no word", m_data);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin
            errors++;
            $display("FAIL order: got %h, required %h", m_data, e);
          end
        end
      end
      stall_prev = m_valid && !m_ready && !flush;
      stall_data = m_data;
      if (flush) exp_q.delete();
      if (fifo_rd_en) begin
        checks++;
        if (fifo_empty) begin
          errors++;
          $display("FAIL underflow: rd_en=1, required 0 with fifo empty");
          fifo_dout <= W'($urandom);
        end else begin
          fifo_dout <= mem[rd_ptr];
          exp_q.push_back(mem[rd_ptr]);
          rd_ptr <= rd_ptr + 1;
        end
      end else begin
        fifo_dout <= W'($urandom);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    push_word(8'hA5);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00 || occupancy !== 2'd0) begin
        errors++;
        $display("FAIL reset_outputs: rd_en=%b valid=%b data=%h occ=%0d, required all 0",
                 fifo_rd_en, m_valid, m_data, occupancy);
      end
      tick();
    end
    rst = 1'b0;
    m_ready = 1'b1;
    #1;
    checks++;
    if (fifo_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL rd_after_reset: got %b, required 1", fifo_rd_en);
    end
    tick();
    #1;
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_t1: valid=%b, required 0", m_valid);
    end
    tick();
    #1;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
      errors++;
      $display("FAIL latency_t2: valid=%b data=%h, required valid=1 data=a5", m_valid, m_data);
    end
    for (int i = 0; i < 10 && !idle(); i++) tick();
  endtask

  task automatic test_stream();
    bit [4:0]     exp_rd = 5'b00111;
    bit [4:0]     exp_v  = 5'b11100;
    logic [W-1:0] exp_d [5] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
    m_ready = 1'b1;
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (fifo_rd_en !== exp_rd[k] || m_valid !== exp_v[k] || (exp_v[k] && m_data !== exp_d[k])) begin
        errors++;
        $display("FAIL stream_t%0d: rd_en=%b valid=%b data=%h, required rd_en=%b valid=%b data=%h",
                 k, fifo_rd_en, m_valid, m_data, exp_rd[k], exp_v[k], exp_d[k]);
      end
      tick();
    end
    #1;
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_end: valid=%b, required 0", m_valid);
    end
  endtask

  task automatic test_stall_fill();
    int pops = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(W'(8'h40 + i));
    for (int k = 0; k < 8; k++) begin
      #1;
      if (fifo_rd_en) pops++;
      tick();
    end
    #1;
    checks++;
    if (pops != 3 || occupancy !== 2'd3 || fifo_rd_en !== 1'b0 || m_valid !== 1'b1 || m_data !== 8'h40) begin
      errors++;
      $display("FAIL stall_fill: pops=%0d occ=%0d rd_en=%b valid=%b data=%h, required 3 3 0 1 40",
               pops, occupancy, fifo_rd_en, m_valid, m_data);
    end
  endtask

  task automatic test_drain();
    int start = delivered;
    int cyc   = 0;
    m_ready = 1'b1;
    while (cyc < 12 && delivered - start < 5) begin
      tick();
      cyc++;
    end
    #1;
    checks++;
    if (delivered - start != 5 || cyc > 6 || occupancy !== 2'd0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: words=%0d cycles=%0d occ=%0d valid=%b, required 5 <=6 0 0",
               delivered - start, cyc, occupancy, m_valid);
    end
  endtask

  task automatic test_flush();
    int i;
    m_ready = 1'b0;
    push_word(8'h71);
    push_word(8'h72);
    push_word(8'h73);
    for (int k = 0; k < 3; k++) tick();
    #1;
    checks++;
    if (occupancy !== 2'd2) begin
      errors++;
      $display("FAIL flush_setup: occ=%0d, required 2", occupancy);
    end
    flush = 1'b1;
    push_word(8'h74);
    #1;
    checks++;
    if (fifo_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL flush_rd_en: got %b, required 0", fifo_rd_en);
    end
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL flush_clear: valid=%b occ=%0d, required 0 0", m_valid, occupancy);
    end
    m_ready = 1'b1;
    for (i = 0; i < 6 && !m_valid; i++) tick();
    #1;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h74) begin
      errors++;
      $display("FAIL flush_next: valid=%b data=%h after %0d cycles, required valid=1 data=74", m_valid, m_data, i);
    end
    for (int j = 0; j < 10 && !idle(); j++) tick();
  endtask

  task automatic test_reset_mid();
    int i;
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) push_word(W'(8'h81 + k));
    for (int k = 0; k < 3; k++) tick();
    #1;
    checks++;
    if (occupancy !== 2'd2) begin
      errors++;
      $display("FAIL rstmid_setup: occ=%0d, required 2", occupancy);
    end
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00 || occupancy !== 2'd0) begin
        errors++;
        $display("FAIL rstmid_outputs: rd_en=%b valid=%b data=%h occ=%0d, required all 0",
                 fifo_rd_en, m_valid, m_data, occupancy);
      end
      tick();
    end
    rst = 1'b0;
    #1;
    checks++;
    if (fifo_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_rd_en: got %b, required 1", fifo_rd_en);
    end
    m_ready = 1'b1;
    for (i = 0; i < 6 && !m_valid; i++) tick();
    #1;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h84) begin
      errors++;
      $display("FAIL rstmid_next: valid=%b data=%h after %0d cycles, required valid=1 data=84", m_valid, m_data, i);
    end
    for (int j = 0; j < 10 && !idle(); j++) tick();
  endtask

  task automatic test_random();
    int n      = 10000;
    int pushed = 0;
    int start  = delivered;
    int cyc    = 0;
    while (cyc < 60000 && !(pushed == n && idle())) begin
      m_ready = 1'($urandom_range(0, 1));
      if (pushed < n && $urandom_range(0, 1) == 1) begin
        push_word(W'($urandom));
        pushed++;
      end
      tick();
      cyc++;
    end
    checks++;
    if (delivered - start != n || exp_q.size() != 0) begin
      errors++;
      $display("FAIL random: delivered=%0d pending=%0d cycles=%0d, required %0d 0",
               delivered - start, exp_q.size(), cyc, n);
    end
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    m_ready    = 1'b0;
    wr_ptr     = 0;
    rd_ptr     = 0;
    fifo_dout  = '0;
    stall_prev = 1'b0;
    stall_data = '0;
    test_reset();
    test_stream();
    test_stall_fill();
    test_drain();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
